control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  in  1  system clock; all state updates occur on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mem_req  out  1  memory access request; held until acknowledged.
REQ-005 mem_we  out  1  write enable, qualified by mem_req (1 = STORE, 0 = read).
REQ-006 mem_addr  out  12  word address: pc during fetch, ir[11:0] during execute.
REQ-007 mem_ack  in  1  memory completion, valid only while mem_req = 1.
REQ-008 mem_rdata  in  16  instruction word, sampled on mem_ack during fetch.
REQ-009 ir_op  out  4  ir[15:12], driven to the opcode decoder.
REQ-010 dec_load, dec_store, dec_add, dec_and, dec_jump, dec_jumpz, dec_comp, dec_rshift  in  1 each  one-hot decode lines returned for ir_op.
REQ-011 ac_zero  in  1  accumulator-equals-zero flag from the datapath.
REQ-012 ac_ld  out  1  single-cycle accumulator load strobe.
REQ-013 alu_sel  out  3  ALU function: PASS=0, ADD=1, AND=2, NOT=3, SHR=4; 0 when ac_ld = 0.
REQ-014 pc  out  12  program counter.
REQ-015 halted  out  1  sticky illegal-instruction indicator.

Function
REQ-016 The FSM SHALL have the states FETCH, DECODE, EXEC and HALT, binary encoded.
REQ-017 FETCH SHALL assert mem_req = 1, mem_we = 0 and mem_addr = pc until mem_ack is high at a clock edge.
REQ-018 On the FETCH ack edge, the block SHALL load ir from mem_rdata, set pc to pc+1 modulo 4096 (12'hFFF wraps to 0), and enter DECODE.
REQ-019 DECODE SHALL last exactly one cycle with mem_req = 0.
REQ-020 In DECODE the block SHALL sample the decode lines and latch the one-hot value into op_q.
REQ-021 If zero or more than one decode line is high, the next state SHALL be HALT; otherwise the next state SHALL be EXEC.
REQ-022 EXEC for LOAD, ADD and AND SHALL assert mem_req = 1, mem_we = 0 and mem_addr = ir[11:0] until ack.
REQ-023 For LOAD, ADD and AND, ac_ld = 1 SHALL be asserted combinationally in the ack cycle only, with alu_sel = PASS, ADD or AND respectively.
REQ-024 EXEC for STORE SHALL assert mem_req = 1, mem_we = 1 and mem_addr = ir[11:0] until ack, and SHALL NOT assert ac_ld.
REQ-025 EXEC for JUMP SHALL last one cycle and set pc to ir[11:0].
REQ-026 EXEC for JUMPZ SHALL last one cycle; pc SHALL become ir[11:0] if ac_zero = 1 in that cycle and SHALL otherwise be unchanged.
REQ-027 EXEC for COMP and RSHIFT SHALL last one cycle with ac_ld = 1 and alu_sel = NOT or SHR respectively.
REQ-028 Every EXEC exit SHALL go to FETCH.
REQ-029 Minimum instruction latency SHALL be 3 cycles (zero-wait memory).
REQ-030 Each memory wait cycle SHALL add one cycle.
REQ-031 mem_req SHALL be 0 in the cycle after any ack.
REQ-032 mem_ack while mem_req = 0 SHALL be ignored.
REQ-033 HALT SHALL hold mem_req = 0, ac_ld = 0 and halted = 1, with pc and ir frozen, until reset.
REQ-034 ir_op SHALL always equal ir[15:12], including in HALT.

Reset
REQ-035 Asserting rst_n = 0 SHALL asynchronously set state = FETCH, pc = 0, ir = 0, op_q = 0 and halted = 0.
REQ-036 While rst_n = 0, mem_req, mem_we and ac_ld SHALL be 0.
REQ-037 Reset asserted mid-fetch or mid-execute SHALL abandon the access with no ac_ld and no pc update.
REQ-038 Fetching SHALL begin from address 0 on the first rising edge after rst_n deasserts.

Structure
REQ-039 Package cpu_pkg SHALL hold the opcode constants (LOAD=0 to RSHIFT=7), the ALU_SEL codes, the state encoding and the widths ADDR_W=12, WORD_W=16, OP_W=4.
REQ-040 The program counter SHALL be a sub-module, pc_reg: a 12-bit counter with asynchronous clear, increment and parallel load, where load has priority.

Verification
REQ-041 Zero-wait fetch at pc=0 with mem_rdata=16'h0123 (LOAD 0x123) -> read at 0x123; ac_ld=1 with alu_sel=0 in cycle 3; pc=1.
REQ-042 STORE 0x0FF with mem_ack delayed 2 cycles -> mem_req=1 and mem_we=1 held 3 cycles at addr 0x0FF; no ac_ld; next fetch at pc+1.
REQ-043 JUMPZ 0x040 run twice: ac_zero=1 -> pc=0x040; ac_zero=0 -> pc unchanged; no mem_req in EXEC.
REQ-044 pc=0xFFF fetching COMP (16'h6000) -> ac_ld=1, alu_sel=3; pc wraps to 0x000.
REQ-045 Opcode 4'hA (all decode lines low) -> HALT after DECODE; halted=1 and mem_req=0 for 20 cycles; rst_n pulse -> halted=0, fetch at 0.
REQ-046 rst_n dropped while EXEC ADD waits for mem_ack -> mem_req falls immediately; no ac_ld; pc=0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select, state and width definitions for the control sequencer.
package cpu_pkg;

    localparam int ADDR_W  = 12;
    localparam int WORD_W  = 16;
    localparam int OP_W    = 4;
    localparam int NUM_OPS = 8;

    localparam logic [OP_W-1:0] OP_LOAD   = 4'd0;
    localparam logic [OP_W-1:0] OP_STORE  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD    = 4'd2;
    localparam logic [OP_W-1:0] OP_AND    = 4'd3;
    localparam logic [OP_W-1:0] OP_JUMP   = 4'd4;
    localparam logic [OP_W-1:0] OP_JUMPZ  = 4'd5;
    localparam logic [OP_W-1:0] OP_COMP   = 4'd6;
    localparam logic [OP_W-1:0] OP_RSHIFT = 4'd7;

    // One-hot decode positions; bit n corresponds to opcode n.
    localparam logic [NUM_OPS-1:0] OH_LOAD   = NUM_OPS'(1) << OP_LOAD;
    localparam logic [NUM_OPS-1:0] OH_STORE  = NUM_OPS'(1) << OP_STORE;
    localparam logic [NUM_OPS-1:0] OH_ADD    = NUM_OPS'(1) << OP_ADD;
    localparam logic [NUM_OPS-1:0] OH_AND    = NUM_OPS'(1) << OP_AND;
    localparam logic [NUM_OPS-1:0] OH_JUMP   = NUM_OPS'(1) << OP_JUMP;
    localparam logic [NUM_OPS-1:0] OH_JUMPZ  = NUM_OPS'(1) << OP_JUMPZ;
    localparam logic [NUM_OPS-1:0] OH_COMP   = NUM_OPS'(1) << OP_COMP;
    localparam logic [NUM_OPS-1:0] OH_RSHIFT = NUM_OPS'(1) << OP_RSHIFT;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_NOT  = 3'd3,
        ALU_SHR  = 3'd4
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
        return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// 12-bit program counter: async clear, increment, parallel load (load wins).
// Single-cycle update; no backpressure.
module pc_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_din,
    output logic [ADDR_W-1:0] o_q
);

    logic [ADDR_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_inc) begin
            r_q <= r_q + ADDR_W'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving memory, ALU select and PC; halts on illegal decode.
// Three cycles per instruction at zero wait; memory waits stretch FETCH/EXEC by one cycle each.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [OP_W-1:0]   ir_op,
    input  logic              dec_load,
    input  logic              dec_store,
    input  logic              dec_add,
    input  logic              dec_and,
    input  logic              dec_jump,
    input  logic              dec_jumpz,
    input  logic              dec_comp,
    input  logic              dec_rshift,
    input  logic              ac_zero,
    output logic              ac_ld,
    output logic [2:0]        alu_sel,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e               r_state;
    state_e               w_next;
    logic [WORD_W-1:0]    r_ir;
    logic [NUM_OPS-1:0]   r_op_q;
    logic                 r_halted;
    logic                 r_ack_q;
    logic [NUM_OPS-1:0]   w_dec;
    logic                 w_req;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_ac_ld;
    alu_sel_e             w_alu;
    logic                 w_pc_inc;
    logic                 w_pc_load;
    logic                 w_ack_acc;
    logic                 w_ac_ld_g;

    assign w_dec = {dec_rshift, dec_comp, dec_jumpz, dec_jump,
                    dec_and, dec_add, dec_store, dec_load};

    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_addr    = pc;
        w_ac_ld   = 1'b0;
        w_alu     = ALU_PASS;
        w_pc_inc  = 1'b0;
        w_pc_load = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // The cycle right after an accepted ack is kept idle on the bus.
                if (!r_ack_q) begin
                    w_req = 1'b1;
                    if (mem_ack) begin
                        w_pc_inc = 1'b1;
                        w_next   = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                w_next = is_onehot(w_dec) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                w_addr = r_ir[ADDR_W-1:0];
                case (r_op_q)
                    OH_LOAD, OH_ADD, OH_AND: begin
                        w_req = 1'b1;
                        if (mem_ack) begin
                            w_ac_ld = 1'b1;
                            w_alu   = (r_op_q == OH_ADD) ? ALU_ADD :
                                      (r_op_q == OH_AND) ? ALU_AND : ALU_PASS;
                            w_next  = ST_FETCH;
                        end
                    end
                    OH_STORE: begin
                        w_req = 1'b1;
                        w_we  = 1'b1;
                        if (mem_ack) begin
                            w_next = ST_FETCH;
                        end
                    end
                    OH_JUMP: begin
                        w_pc_load = 1'b1;
                        w_next    = ST_FETCH;
                    end
                    OH_JUMPZ: begin
                        w_pc_load = ac_zero;
                        w_next    = ST_FETCH;
                    end
                    OH_COMP: begin
                        w_ac_ld = 1'b1;
                        w_alu   = ALU_NOT;
                        w_next  = ST_FETCH;
                    end
                    OH_RSHIFT: begin
                        w_ac_ld = 1'b1;
                        w_alu   = ALU_SHR;
                        w_next  = ST_FETCH;
                    end
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    assign w_ack_acc = w_req & mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FETCH;
            r_ir     <= '0;
            r_op_q   <= '0;
            r_halted <= 1'b0;
            r_ack_q  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack_q <= w_ack_acc;
            if (r_state == ST_FETCH && w_ack_acc) begin
                r_ir <= mem_rdata;
            end
            if (r_state == ST_DECODE) begin
                r_op_q <= w_dec;
                if (w_next == ST_HALT) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    pc_reg u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_pc_inc),
        .i_load (w_pc_load),
        .i_din  (r_ir[ADDR_W-1:0]),
        .o_q    (pc)
    );

    // Reset forces the bus and load strobe quiet even though the state resets to FETCH.
    assign w_ac_ld_g = w_ac_ld & rst_n;
    assign mem_req   = w_req & rst_n;
    assign mem_we    = w_we & rst_n;
    assign mem_addr  = w_addr;
    assign ac_ld     = w_ac_ld_g;
    assign alu_sel   = w_ac_ld_g ? w_alu : ALU_PASS;
    assign ir_op     = r_ir[WORD_W-1:WORD_W-OP_W];
    assign halted    = r_halted;

endmodule
